// File: rtl/powlib_dpram_reader_pkg.sv
// Shared helpers for the dual-port RAM reader: index width and gray coding.
package powlib_dpram_reader_pkg;

  // Smallest r with 2**r >= v.
  function automatic int clogb2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Binary to gray; callers cast the result down to their pointer width.
  function automatic logic [31:0] gray_enc(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: bit i is the xor of all gray bits at or above i.
  function automatic logic [31:0] gray_dec(input logic [31:0] g);
    logic [31:0] b;
    for (int i = 0; i < 32; i++) b[i] = ^(g >> i);
    return b;
  endfunction

endpackage

// File: rtl/powlib_dpram_reader_if.sv
// Pointer, RAM read port and output stream bundle of the reader.
// master = reader side, slave = writer/RAM/consumer side.
interface powlib_dpram_reader_if #(
  parameter int W    = 32,
  parameter int WIDX = 7
);
  localparam int PW = WIDX + 1;

  logic [PW-1:0]   wrptr;
  logic [PW-1:0]   rdptr;
  logic [PW-1:0]   lvl;
  logic [WIDX-1:0] rdidx;
  logic            rdrdy;
  logic [W-1:0]    rddata;
  logic [W-1:0]    outdata;
  logic            outvld;
  logic            outrdy;

  modport master (
    input  wrptr, rddata, outrdy,
    output rdptr, rdidx, rdrdy, lvl, outdata, outvld
  );

  modport slave (
    output wrptr, rddata, outrdy,
    input  rdptr, rdidx, rdrdy, lvl, outdata, outvld
  );
endinterface

// File: rtl/powlib_dpram_reader_buf.sv
// 2-entry synchronous FIFO that absorbs RAM read latency in front of the
// output stream. The caller never pushes while full without a pop.
module powlib_dpram_reader_buf
  import powlib_dpram_reader_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] pushdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         vld,
  output logic [1:0]   occ
);
  logic [1:0][W-1:0] mem;
  logic              wp;
  logic              rp;

  // Slot pointers and occupancy; push and pop together leave occ unchanged.
  always_ff @(posedge clk) begin
    if (!rst) begin
      occ <= 2'd0;
      wp  <= 1'b0;
      rp  <= 1'b0;
    end else begin
      if (push) wp <= ~wp;
      if (pop)  rp <= ~rp;
      occ <= occ + 2'(push) - 2'(pop);
    end
  end

  // Storage needs no reset; vld masks stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= pushdata;
  end

  assign head = mem[rp];
  assign vld  = (occ != 2'd0);
endmodule

// File: rtl/powlib_dpram_reader.sv
// Read-side controller of the dual-port RAM FIFO: issues RAM reads while
// words are available and the 2-entry buffer has room, and streams them out.
// Optional macro POWLIB_DPRAM_READER_GRAY_EN: wrptr arrives gray-coded and
// rdptr leaves gray-coded (registered, one cycle behind the binary pointer).
module powlib_dpram_reader
  import powlib_dpram_reader_pkg::*;
#(
  parameter int W    = 32,
  parameter int D    = 128,
  parameter int WIDX = clogb2(D),
  parameter int ERRD = 0
) (
  input logic                   clk,
  input logic                   rst,
  powlib_dpram_reader_if.master bus
);
  localparam int PW = WIDX + 1;

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] rd_bin;
  logic [1:0]    occ;
  logic [2:0]    need;
  logic          vld;
  logic          infl;
  logic          push;
  logic          pop;
  logic          empty;
  logic          issue;

`ifdef POWLIB_DPRAM_READER_GRAY_EN
  assign wr_bin = PW'(gray_dec(32'(bus.wrptr)));
`else
  assign wr_bin = bus.wrptr;
`endif

  // Slots already committed (buffered + in flight) minus the one leaving now.
  assign empty = (wr_bin == rd_bin);
  assign pop   = vld & bus.outrdy;
  assign need  = 3'(occ) + 3'(infl) - 3'(pop);
  assign issue = !empty && (need < 3'd2);

  // Binary read pointer advances on every issued read.
  always_ff @(posedge clk) begin
    if (!rst) rd_bin <= '0;
    else if (issue) rd_bin <= rd_bin + PW'(1);
  end

  generate
    if (ERRD != 0) begin : g_reg_read
      // Registered RAM: data for an issue arrives on the following cycle.
      always_ff @(posedge clk) begin
        if (!rst) infl <= 1'b0;
        else      infl <= issue;
      end
      assign push = infl;
    end else begin : g_comb_read
      assign infl = 1'b0;
      assign push = issue;
    end
  endgenerate

`ifdef POWLIB_DPRAM_READER_GRAY_EN
  logic [PW-1:0] rd_gray;

  // Gray copy registered for a clean crossing into the writer's domain.
  always_ff @(posedge clk) begin
    if (!rst) rd_gray <= '0;
    else      rd_gray <= PW'(gray_enc(32'(rd_bin)));
  end
  assign bus.rdptr = rd_gray;
`else
  assign bus.rdptr = rd_bin;
`endif

  assign bus.rdidx  = rd_bin[WIDX-1:0];
  assign bus.rdrdy  = issue;
  assign bus.lvl    = wr_bin - rd_bin;
  assign bus.outvld = vld;

  powlib_dpram_reader_buf #(.W(W)) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushdata (bus.rddata),
    .pop      (pop),
    .head     (bus.outdata),
    .vld      (vld),
    .occ      (occ)
  );
endmodule
